seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter that sources the single-bit `x` stream consumed by the sequence-detector blocks (`SEQDET_*`). A pattern word and bit length are loaded through a valid/ready port. The block then shifts the pattern out MSB-first, one bit per clock, either once or looped without gaps. It replaces hard-coded rotate registers in benches and drives detectors in on-chip self-test.

---
 rtl/seq_gen_pkg.sv | 31 +++
 rtl/seq_piso_reg.sv | 41 ++++
 rtl/seq_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen_pkg
// Description : Shared types and helpers for the serial pattern generator.
//               Holds the FSM state encoding, default sizing constants and
//               the load-length clamp function.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

   localparam int unsigned c_default_width = 24;
   localparam int unsigned c_default_cnt_w = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // A length of zero means "full register"; anything wider than the
   // register is limited to the register width.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned width);
      if ((len == 0) || (len > width)) begin
         return width;
      end
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_piso_reg.sv
`default_nettype none
// ============================================================================
// Module      : seq_piso_reg
// Description : Parallel-load, serial-out left-shift register. Load has
//               priority over shift; shifting fills with zeros.
// Ports       : Clk, rst_n (sync, active-low)
//               i_load  - capture i_data
//               i_shift - shift left by one, zero fill
//               i_data  - parallel load value
//               o_msb   - current MSB (serial output bit)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_piso_reg
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width
) (
   input  logic             Clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_data;
      end else if (i_shift) begin
         r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
   end

   assign o_msb = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_gen
// Description : Serial bit-pattern transmitter. A pattern, length and loop
//               flag are loaded over a valid/ready port, then shifted out
//               MSB-first one bit per clock, once or looped without gaps.
// Ports       : Clk, rst_n (sync, active-low)
//               i_load_valid / o_load_ready - load handshake
//               i_load_pattern, i_load_len, i_load_loop - load payload
//               i_start - begin transmission, i_halt - abort
//               o_x, o_x_valid - serial data and qualifier
//               o_busy - shifting, o_done - end-of-run pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width,
   parameter int unsigned CNT_W = c_default_cnt_w
) (
   input  logic             Clk,
   input  logic             rst_n,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   input  logic [WIDTH-1:0] i_load_pattern,
   input  logic [CNT_W-1:0] i_load_len,
   input  logic             i_load_loop,
   input  logic             i_start,
   input  logic             i_halt,
   output logic             o_x,
   output logic             o_x_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_pat;
   logic [CNT_W-1:0] r_len;
   logic             r_loop;
   logic [CNT_W-1:0] r_cnt;
   logic             r_x_valid;
   logic             r_busy;
   logic             r_done;

   logic             w_ld_fire;
   logic             w_last;
   logic             w_sh_load;
   logic             w_sh_shift;
   logic [WIDTH-1:0] w_sh_din;
   logic             w_sh_msb;

   assign w_ld_fire = i_load_valid && (r_state != ST_SHIFT);
   assign w_last    = (r_cnt == (r_len - c_one));

   // The shift register doubles as the serial output register: it is
   // reloaded with zeros whenever a run ends so o_x reads 0 outside SHIFT.
   always_comb begin
      w_sh_load  = 1'b0;
      w_sh_shift = 1'b0;
      w_sh_din   = r_pat;
      case (r_state)
         ST_ARMED: begin
            if (!w_ld_fire && i_start) begin
               w_sh_load = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (i_halt) begin
               w_sh_load = 1'b1;
               w_sh_din  = '0;
            end else if (w_last) begin
               w_sh_load = 1'b1;
               w_sh_din  = r_loop ? r_pat : '0;
            end else begin
               w_sh_shift = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   seq_piso_reg #(
      .WIDTH (WIDTH)
   ) u_piso (
      .Clk     (Clk),
      .rst_n   (rst_n),
      .i_load  (w_sh_load),
      .i_shift (w_sh_shift),
      .i_data  (w_sh_din),
      .o_msb   (w_sh_msb)
   );

   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pat     <= '0;
         r_len     <= '0;
         r_loop    <= 1'b0;
         r_cnt     <= '0;
         r_x_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_ARMED: begin
               if (w_ld_fire) begin
                  // A load always wins over a simultaneous start.
                  r_pat   <= i_load_pattern;
                  r_len   <= CNT_W'(clamp_len(32'(i_load_len), WIDTH));
                  r_loop  <= i_load_loop;
                  r_state <= ST_ARMED;
               end else if ((r_state == ST_ARMED) && i_start) begin
                  r_cnt     <= '0;
                  r_x_valid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (i_halt) begin
                  r_x_valid <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= ST_ARMED;
               end else if (w_last) begin
                  r_cnt <= '0;
                  if (!r_loop) begin
                     r_x_valid <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= ST_ARMED;
                  end
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_load_ready = (r_state != ST_SHIFT);
   assign o_x          = w_sh_msb;
   assign o_x_valid    = r_x_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Self-checking bench for seq_pattern_gen: table of single-run
//               vectors plus directed loop, halt, handshake and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

   logic        Clk;
   logic        rst_n;
   logic        i_load_valid;
   logic        o_load_ready;
   logic [23:0] i_load_pattern;
   logic [4:0]  i_load_len;
   logic        i_load_loop;
   logic        i_start;
   logic        i_halt;
   logic        o_x;
   logic        o_x_valid;
   logic        o_busy;
   logic        o_done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [23:0] pat;   // expected stream, MSB first
      logic [4:0]  len;
      int          n;     // expected number of bits sent
   } vec_t;

   vec_t vecs[5];

   seq_pattern_gen #(
      .WIDTH (24),
      .CNT_W (5)
   ) dut (
      .Clk            (Clk),
      .rst_n          (rst_n),
      .i_load_valid   (i_load_valid),
      .o_load_ready   (o_load_ready),
      .i_load_pattern (i_load_pattern),
      .i_load_len     (i_load_len),
      .i_load_loop    (i_load_loop),
      .i_start        (i_start),
      .i_halt         (i_halt),
      .o_x            (o_x),
      .o_x_valid      (o_x_valid),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [23:0] p, input logic [4:0] l,
                          input logic lp);
      int k;
      i_load_valid   = 1'b1;
      i_load_pattern = p;
      i_load_len     = l;
      i_load_loop    = lp;
      k = 0;
      while (!o_load_ready && k < 60) begin
         tick();
         k++;
      end
      chk("load_ready wait", o_load_ready, 1'b1);
      tick();
      i_load_valid = 1'b0;
      chk("armed ready", o_load_ready, 1'b1);
      chk("armed busy", o_busy, 1'b0);
   endtask

   // Start a non-loop run and check every bit, the done pulse and its end.
   task automatic run_once(input logic [23:0] p, input int n, input string tag);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s x_valid bit %0d", tag, i), o_x_valid, 1'b1);
         chk($sformatf("%s x bit %0d", tag, i), o_x, p[23-i]);
         chk($sformatf("%s busy bit %0d", tag, i), o_busy, 1'b1);
         tick();
      end
      chk({tag, " done"}, o_done, 1'b1);
      chk({tag, " x_valid after"}, o_x_valid, 1'b0);
      chk({tag, " x after"}, o_x, 1'b0);
      chk({tag, " ready in done"}, o_load_ready, 1'b1);
      tick();
      chk({tag, " done one cycle"}, o_done, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] lp5;

      vecs[0] = '{24'h0CD124, 5'd24, 24};
      vecs[1] = '{24'hA5F00F, 5'd0,  24};
      vecs[2] = '{24'h3C0001, 5'd30, 24};
      vecs[3] = '{24'hF00000, 5'd4,  4};
      vecs[4] = '{24'h800000, 5'd1,  1};

      // Reset with activity on the inputs.
      rst_n          = 1'b0;
      i_load_valid   = 1'b1;
      i_load_pattern = 24'hFFFFFF;
      i_load_len     = 5'd8;
      i_load_loop    = 1'b0;
      i_start        = 1'b1;
      i_halt         = 1'b0;
      tick(); tick(); tick();
      chk("rst load_ready", o_load_ready, 1'b1);
      chk("rst x", o_x, 1'b0);
      chk("rst x_valid", o_x_valid, 1'b0);
      chk("rst busy", o_busy, 1'b0);
      chk("rst done", o_done, 1'b0);
      rst_n        = 1'b1;
      i_load_valid = 1'b0;
      tick(); tick();
      chk("idle start ignored busy", o_busy, 1'b0);
      chk("idle start ignored x_valid", o_x_valid, 1'b0);
      i_start = 1'b0;

      // Single non-loop runs, including length clamping.
      for (int v = 0; v < 5; v++) begin
         do_load(vecs[v].pat, vecs[v].len, 1'b0);
         run_once(vecs[v].pat, vecs[v].n, $sformatf("vec%0d", v));
      end

      // Loop mode: 10010 repeating, halt after 12 bits.
      lp5 = 5'b10010;
      do_load(24'h900000, 5'd5, 1'b1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("loop x_valid bit %0d", i), o_x_valid, 1'b1);
         chk($sformatf("loop x bit %0d", i), o_x, lp5[4 - (i % 5)]);
         chk($sformatf("loop done bit %0d", i), o_done, 1'b0);
         if (i == 11) i_halt = 1'b1;
         tick();
      end
      i_halt = 1'b0;
      chk("loop halt x_valid", o_x_valid, 1'b0);
      chk("loop halt x", o_x, 1'b0);
      chk("loop halt busy", o_busy, 1'b0);
      chk("loop halt done", o_done, 1'b0);
      chk("loop halt ready", o_load_ready, 1'b1);
      tick();
      chk("loop halt no done", o_done, 1'b0);

      // Halt on the last bit of a non-loop run suppresses done.
      do_load(24'hF0F000, 5'd4, 1'b0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("halt-last x bit %0d", i), o_x, 1'b1);
         if (i == 3) i_halt = 1'b1;
         tick();
      end
      i_halt = 1'b0;
      chk("halt-last done", o_done, 1'b0);
      chk("halt-last x_valid", o_x_valid, 1'b0);
      tick();
      chk("halt-last no done", o_done, 1'b0);

      // Load request held during SHIFT is stalled, then taken in done cycle.
      do_load(24'hC30000, 5'd8, 1'b0);
      i_start = 1'b1;
      tick();
      i_start        = 1'b0;
      i_load_valid   = 1'b1;
      i_load_pattern = 24'h5A0000;
      i_load_len     = 5'd8;
      i_load_loop    = 1'b0;
      lp5 = 5'b0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] a;
         a = 8'hC3;
         chk($sformatf("hs ready bit %0d", i), o_load_ready, 1'b0);
         chk($sformatf("hs x bit %0d", i), o_x, a[7-i]);
         tick();
      end
      chk("hs done", o_done, 1'b1);
      chk("hs ready in done", o_load_ready, 1'b1);
      tick();
      i_load_valid = 1'b0;
      run_once(24'h5A0000, 8, "hs new");

      // Load and start in the same ARMED cycle: start is ignored.
      i_load_valid   = 1'b1;
      i_load_pattern = 24'h3C0000;
      i_load_len     = 5'd6;
      i_load_loop    = 1'b0;
      i_start        = 1'b1;
      tick();
      i_load_valid = 1'b0;
      i_start      = 1'b0;
      chk("ld+start busy", o_busy, 1'b0);
      chk("ld+start x_valid", o_x_valid, 1'b0);
      tick();
      chk("ld+start still idle", o_busy, 1'b0);
      run_once(24'h3C0000, 6, "ld+start");

      // Mid-run reset at bit 7.
      do_load(24'hAAAAAA, 5'd24, 1'b0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("mid bit7 x", o_x, 1'b0);
      chk("mid bit7 x_valid", o_x_valid, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("mid rst ready", o_load_ready, 1'b1);
      chk("mid rst x", o_x, 1'b0);
      chk("mid rst x_valid", o_x_valid, 1'b0);
      chk("mid rst busy", o_busy, 1'b0);
      chk("mid rst done", o_done, 1'b0);
      rst_n   = 1'b1;
      i_start = 1'b1;
      tick(); tick();
      chk("mid rst idle busy", o_busy, 1'b0);
      chk("mid rst idle x_valid", o_x_valid, 1'b0);
      i_start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
